// File: rtl/mem_access_unit.sv
// Load/store front end for the 8-bit memory block.
// Core requests arrive on a valid/ready channel; load data returns on a valid/ready response channel.
module mem_access_unit #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_address,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_operation,
    output logic [DATA_W-1:0] o_mem_input_value,
    input  logic [DATA_W-1:0] i_mem_value,
    output logic              o_busy
);

    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_mem_address;
    logic               r_mem_operation;
    logic [DATA_W-1:0]  r_mem_input_value;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // During ACCESS the registered operation bit tells a store (1) from a load (0).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_req_valid)  w_next_state = ACCESS;
            ACCESS:  w_next_state = r_mem_operation ? IDLE : WAIT;
            WAIT:    if (w_cnt_last)   w_next_state = RESP;
            RESP:    if (i_resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (r_state == IDLE);
        o_busy      = (r_state != IDLE);
    end

    // Async reset also drops the write strobe, so an interrupted store never commits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt             <= '0;
            r_mem_address     <= '0;
            r_mem_operation   <= 1'b0;
            r_mem_input_value <= '0;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_mem_address     <= i_req_address;
                        r_mem_input_value <= i_req_wdata;
                        r_mem_operation   <= i_req_write;
                    end
                end
                ACCESS: begin
                    r_mem_operation <= 1'b0;
                    if (!r_mem_operation) begin
                        r_cnt <= CNT_W'(READ_LATENCY);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_cnt_last) begin
                        r_resp_rdata <= i_mem_value;
                        r_resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_mem_operation <= 1'b0;
                    r_resp_valid    <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_address     = r_mem_address;
    assign o_mem_operation   = r_mem_operation;
    assign o_mem_input_value = r_mem_input_value;
    assign o_resp_valid      = r_resp_valid;
    assign o_resp_rdata      = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a synchronous-read memory model behind the unit,
// directed load/store vectors, and a queue of expected load data drained by a response monitor.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       rstN;
    logic       reqValid;
    logic       reqReady;
    logic       reqWrite;
    logic [7:0] reqAddress;
    logic [7:0] reqWdata;
    logic       respValid;
    logic       respReady;
    logic [7:0] respRdata;
    logic [7:0] memAddr;
    logic       memOp;
    logic [7:0] memIn;
    logic [7:0] memValue;
    logic       busy;

    logic [7:0] memArr [256];
    int         writeCount = 0;

    logic [7:0] expQ [$];
    int         nCompared   = 0;
    int         nMismatched = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) dut (
        .i_clk             (clk),
        .i_rst_n           (rstN),
        .i_req_valid       (reqValid),
        .o_req_ready       (reqReady),
        .i_req_write       (reqWrite),
        .i_req_address     (reqAddress),
        .i_req_wdata       (reqWdata),
        .o_resp_valid      (respValid),
        .i_resp_ready      (respReady),
        .o_resp_rdata      (respRdata),
        .o_mem_address     (memAddr),
        .o_mem_operation   (memOp),
        .o_mem_input_value (memIn),
        .i_mem_value       (memValue),
        .o_busy            (busy)
    );

    // Memory model: samples address and write strobe on posedge, read data one cycle later.
    always @(posedge clk) begin
        if (memOp) begin
            memArr[memAddr] <= memIn;
            writeCount      <= writeCount + 1;
        end
        memValue <= memArr[memAddr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        reqValid   = v;
        reqWrite   = w;
        reqAddress = a;
        reqWdata   = d;
    endtask

    // Response monitor: every completed handshake pops one expected load value.
    always @(negedge clk) begin
        if (rstN && respValid && respReady) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_resp: got rdata %0d, expected no response", respRdata);
            end else begin
                checkOutput("resp_rdata", int'(respRdata), int'(expQ.pop_front()));
            end
        end
    end

    task automatic doStore(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("store_op_high", int'(memOp), 1);
        checkOutput("store_addr", int'(memAddr), int'(a));
        checkOutput("store_data", int'(memIn), int'(d));
        checkOutput("store_ready_low", int'(reqReady), 0);
        checkOutput("store_no_resp", int'(respValid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("store_op_one_cycle", int'(memOp), 0);
        checkOutput("store_ready_back", int'(reqReady), 1);
        checkOutput("store_no_resp_after", int'(respValid), 0);
    endtask

    task automatic issueLoad(input logic [7:0] a, input logic [7:0] expData);
        int  edges;
        bit  opSeen;
        expQ.push_back(expData);
        applyStimulus(1'b1, 1'b0, a, 8'h00);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        edges  = 0;
        opSeen = memOp;
        while (!respValid && edges < 10) begin
            @(posedge clk);
            edges++;
            #1;
            opSeen = opSeen | memOp;
        end
        checkOutput("load_latency", edges, 2);
        checkOutput("load_op_low", int'(opSeen), 0);
    endtask

    task automatic waitResp();
        int cycles = 0;
        while (expQ.size() != 0 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("resp_pending", expQ.size(), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wcBefore;
        rstN      = 1'b0;
        respReady = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // 1: reset state
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_addr", int'(memAddr), 0);
        checkOutput("rst_mem_op", int'(memOp), 0);
        checkOutput("rst_mem_in", int'(memIn), 0);
        checkOutput("rst_resp_valid", int'(respValid), 0);
        checkOutput("rst_req_ready", int'(reqReady), 1);
        checkOutput("rst_busy", int'(busy), 0);

        // 2: store 12 to address 9
        doStore(8'd9, 8'd12);

        // 3: load address 9
        issueLoad(8'd9, 8'h0C);
        waitResp();

        // 4: load with response held off for 4 cycles, competing request ignored
        respReady = 1'b0;
        wcBefore  = writeCount;
        issueLoad(8'd9, 8'h0C);
        applyStimulus(1'b1, 1'b1, 8'd3, 8'h55);
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold_resp_valid", int'(respValid), 1);
            checkOutput("hold_resp_rdata", int'(respRdata), 12);
            checkOutput("hold_req_ready", int'(reqReady), 0);
            checkOutput("hold_mem_addr", int'(memAddr), 9);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        respReady = 1'b1;
        waitResp();
        @(negedge clk);
        checkOutput("hold_release_ready", int'(reqReady), 1);
        checkOutput("hold_no_write", writeCount, wcBefore);

        // 5: back-to-back store then load with req_valid held
        applyStimulus(1'b1, 1'b1, 8'd9, 8'd7);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 8'd9, 8'd0);
        @(negedge clk);
        checkOutput("b2b_store_op", int'(memOp), 1);
        checkOutput("b2b_store_data", int'(memIn), 7);
        @(posedge clk); #1;
        expQ.push_back(8'd7);
        @(negedge clk);
        checkOutput("b2b_idle_ready", int'(reqReady), 1);
        checkOutput("b2b_op_low", int'(memOp), 0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("b2b_load_busy", int'(busy), 1);
        checkOutput("b2b_load_addr", int'(memAddr), 9);
        checkOutput("b2b_load_op", int'(memOp), 0);
        waitResp();

        // 6: reset during a store's ACCESS cycle
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 8'd9, 8'd8);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("abort_op_before", int'(memOp), 1);
        wcBefore = writeCount;
        rstN = 1'b0;
        #1;
        checkOutput("abort_op_forced", int'(memOp), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_addr", int'(memAddr), 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        checkOutput("abort_no_write", writeCount, wcBefore);
        @(negedge clk);
        issueLoad(8'd9, 8'd7);
        waitResp();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
